// File: rtl/prbs_checker.sv
// PRBS checker: seeds from the stream, locks after LOCK_CNT matches, counts errors while locked.
// Latency: locked/err_pulse/err_count update one cycle after the valid sample. No backpressure; every in_valid sample is consumed.
// Optional PRBS_CHECKER_PERIOD_EN adds period/period_valid measurement of the sequence length.
module prbs_checker #(
    parameter int N        = 4,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int CW       = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [N-1:0]  in_data,
    input  logic [N-1:0]  mask,
    input  logic          clr,
    output logic          locked,
    output logic          err_pulse,
    output logic [CW-1:0] err_count
`ifdef PRBS_CHECKER_PERIOD_EN
    ,
    output logic [CW-1:0] period,
    output logic          period_valid
`endif
);

    typedef enum logic [1:0] {IDLE, SYNC, LOCKED} state_t;

    localparam logic [3:0]    LOCK_TGT = 4'(LOCK_CNT);
    localparam logic [3:0]    LOSS_TGT = 4'(LOSS_CNT);
    localparam logic [CW-1:0] SAT      = '1;

    state_t        state, state_nxt;
    logic [N-1:0]  exp_word, exp_nxt;
    logic [3:0]    match_cnt, match_nxt, miss_cnt, miss_nxt;
    logic          hit, count_err, lock_entry;

    function automatic logic [N-1:0] step(input logic [N-1:0] x, input logic [N-1:0] m);
        return {x[N-2:0], ^(x & m)};
    endfunction

    always_comb begin
        state_nxt = state;
        exp_nxt   = exp_word;
        match_nxt = match_cnt;
        miss_nxt  = miss_cnt;
        count_err = 1'b0;
        hit       = (in_data == exp_word);
        if (in_valid) begin
            case (state)
                IDLE: begin
                    // all-zero is the LFSR lockup word and can never seed a sequence
                    if (in_data != '0) begin
                        exp_nxt   = step(in_data, mask);
                        match_nxt = 4'd0;
                        state_nxt = SYNC;
                    end
                end
                SYNC: begin
                    exp_nxt = step(in_data, mask);
                    if (hit) begin
                        match_nxt = match_cnt + 4'd1;
                        if (match_cnt + 4'd1 == LOCK_TGT) begin
                            state_nxt = LOCKED;
                            miss_nxt  = 4'd0;
                        end
                    end else begin
                        match_nxt = 4'd0;
                        if (in_data == '0)
                            state_nxt = IDLE;
                    end
                end
                LOCKED: begin
                    if (hit) begin
                        exp_nxt  = step(exp_word, mask);
                        miss_nxt = 4'd0;
                    end else begin
                        count_err = 1'b1;
                        miss_nxt  = miss_cnt + 4'd1;
                        if (miss_cnt + 4'd1 == LOSS_TGT) begin
                            state_nxt = SYNC;
                            match_nxt = 4'd0;
                            exp_nxt   = step(in_data, mask);
                        end else begin
                            // free-run so a single bit error does not corrupt the reference
                            exp_nxt = step(exp_word, mask);
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign lock_entry = in_valid && (state == SYNC) && (state_nxt == LOCKED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            exp_word  <= '0;
            match_cnt <= 4'd0;
            miss_cnt  <= 4'd0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_nxt;
            exp_word  <= exp_nxt;
            match_cnt <= match_nxt;
            miss_cnt  <= miss_nxt;
            locked    <= (state_nxt == LOCKED);
            err_pulse <= count_err;
            if (clr)
                err_count <= count_err ? CW'(1) : '0;
            else if (count_err && err_count != SAT)
                err_count <= err_count + CW'(1);
        end
    end

`ifdef PRBS_CHECKER_PERIOD_EN
    logic [N-1:0]  ref_word;
    logic [CW-1:0] per_cnt, per_inc;

    assign per_inc = (per_cnt == SAT) ? per_cnt : per_cnt + CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_word     <= '0;
            per_cnt      <= '0;
            period       <= '0;
            period_valid <= 1'b0;
        end else if (lock_entry) begin
            ref_word <= in_data;
            per_cnt  <= '0;
        end else if (state == LOCKED && state_nxt != LOCKED) begin
            period_valid <= 1'b0;
        end else if (state == LOCKED && in_valid) begin
            if (in_data == ref_word) begin
                period       <= per_inc;
                period_valid <= 1'b1;
                per_cnt      <= '0;
            end else begin
                per_cnt <= per_inc;
            end
        end
    end
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: expected outputs are queued when each sample is driven and
// compared one cycle later; optional period ports are checked when PRBS_CHECKER_PERIOD_EN is defined.
module tb_prbs_checker;
    localparam int N  = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [N-1:0]  in_data = '0;
    logic [N-1:0]  mask = 4'b0110;
    logic          clr = 1'b0;
    logic          locked, err_pulse;
    logic [CW-1:0] err_count;
`ifdef PRBS_CHECKER_PERIOD_EN
    logic [CW-1:0] period;
    logic          period_valid;
`endif

    prbs_checker #(.N(N), .LOCK_CNT(4), .LOSS_CNT(3), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .mask      (mask),
        .clr       (clr),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count)
`ifdef PRBS_CHECKER_PERIOD_EN
        ,
        .period       (period),
        .period_valid (period_valid)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          l;
        logic          p;
        logic [CW-1:0] c;
    } exp_t;

    exp_t         sb[$];
    string        tags[$];
    int           compared = 0;
    int           mism = 0;
    int           p = 0;
    logic [N-1:0] seq [7] = '{4'h5, 4'hB, 4'h7, 4'hE, 4'hC, 4'h9, 4'h2};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mism++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic v, input logic [N-1:0] d, input logic c,
                         input logic el, input logic ep, input logic [CW-1:0] ec, input string tag);
        exp_t e;
        string t;
        in_valid = v;
        in_data  = d;
        clr      = c;
        sb.push_back('{l: el, p: ep, c: ec});
        tags.push_back(tag);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        t = tags.pop_front();
        chk({t, ".locked"}, 32'(locked), 32'(e.l));
        chk({t, ".err_pulse"}, 32'(err_pulse), 32'(e.p));
        chk({t, ".err_count"}, 32'(err_count), 32'(e.c));
    endtask

    task automatic good(input logic el, input logic [CW-1:0] ec, input string tag, input logic c = 1'b0);
        drive(1'b1, seq[p % 7], c, el, 1'b0, ec, tag);
        p++;
    endtask

    task automatic bad(input logic el, input logic [CW-1:0] ec, input string tag, input logic c = 1'b0);
        drive(1'b1, ~seq[p % 7], c, el, 1'b1, ec, tag);
        p++;
    endtask

    initial begin
        #3;
        chk("rst.locked", 32'(locked), 0);
        chk("rst.err_pulse", 32'(err_pulse), 0);
        chk("rst.err_count", 32'(err_count), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // seed + 4 matches -> locked after the 5th sample; run on to the first recurrence of ref word
        for (int i = 0; i < 12; i++) begin
            good(i >= 4, 0, "acq");
`ifdef PRBS_CHECKER_PERIOD_EN
            if (i == 10) chk("period_valid.early", 32'(period_valid), 0);
`endif
        end
`ifdef PRBS_CHECKER_PERIOD_EN
        chk("period_valid", 32'(period_valid), 1);
        chk("period", 32'(period), 7);
`endif

        // single corrupted sample: 1110 replaced with 1111
        for (int i = 0; i < 5; i++) good(1, 0, "pre1");
        drive(1'b1, 4'hF, 1'b0, 1'b1, 1'b1, 1, "single");
        p++;
        for (int i = 0; i < 3; i++) good(1, 1, "post1");

        // three consecutive errors drop lock; relock needs reseed + 4 matches
        bad(1, 2, "loss1");
        bad(1, 3, "loss2");
        bad(0, 4, "loss3");
`ifdef PRBS_CHECKER_PERIOD_EN
        chk("period_valid.loss", 32'(period_valid), 0);
`endif
        for (int i = 0; i < 5; i++) good(i == 4, 4, "relock");

        // clear coincident with a counted mismatch, idle cycle, then plain clear
        bad(1, 1, "clr_err", 1'b1);
        drive(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1, "idle");
        good(1, 1, "after_idle");
        good(1, 0, "clr_only", 1'b1);

        // five spaced errors, then asynchronous reset between clock edges
        for (int k = 1; k <= 5; k++) begin
            bad(1, CW'(k), "err5");
            good(1, CW'(k), "err5_ok");
        end
        #2 rst = 1'b1;
        #1;
        chk("arst.locked", 32'(locked), 0);
        chk("arst.err_count", 32'(err_count), 0);
        chk("arst.err_pulse", 32'(err_pulse), 0);
`ifdef PRBS_CHECKER_PERIOD_EN
        chk("arst.period_valid", 32'(period_valid), 0);
        chk("arst.period", 32'(period), 0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;

        // lockup word never seeds; then a fresh acquisition
        for (int i = 0; i < 3; i++) drive(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 0, "zero");
        for (int i = 0; i < 5; i++) good(i == 4, 0, "fresh");

        // error counter saturates at 2^CW-1
        for (int k = 1; k <= 16; k++) begin
            bad(1, CW'((k > 15) ? 15 : k), "sat");
            good(1, CW'((k > 15) ? 15 : k), "sat_ok");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end
endmodule

// File: doc/prbs_checker.md
PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 Parameter N, default 4, LFSR word width; legal range 2..32.
REQ-002 Parameter LOCK_CNT, default 4, consecutive matches needed to lock; legal range 1..15.
REQ-003 Parameter LOSS_CNT, default 3, consecutive mismatches needed to drop lock; legal range 1..15.
REQ-004 Parameter CW, default 16, width of the error and period counters.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 in_valid  input  1  in_data carries a new LFSR word this cycle.
REQ-008 in_data  input  N  word from the upstream lfsr q output.
REQ-009 mask  input  N  feedback tap mask, identical to the upstream lfsr mask; held static while not in IDLE.
REQ-010 clr  input  1  synchronous clear of err_count.
REQ-011 locked  output  1  checker is in LOCKED state.
REQ-012 err_pulse  output  1  one-cycle strobe per mismatching sample while LOCKED.
REQ-013 err_count  output  CW  saturating mismatch count.

Function
REQ-014 Step function next(x) = {x[N-2:0], ^(x & mask)}, i.e. shift left with mask-parity feedback into bit 0.
REQ-015 Internal expected word exp (N bits); cycles with in_valid=0 change no state and deassert err_pulse.
REQ-016 States: IDLE, SYNC, LOCKED. Encoding is free.
REQ-017 IDLE: on in_valid with in_data != 0, exp <= next(in_data), match_cnt <= 0, go to SYNC; in_data == 0 is ignored (lockup word).
REQ-018 SYNC, in_valid with in_data == exp: exp <= next(in_data), match_cnt++; on reaching LOCK_CNT, go to LOCKED with miss_cnt <= 0.
REQ-019 SYNC, in_valid with in_data != exp: match_cnt <= 0, exp <= next(in_data) (reseed); in_data == 0 sends the FSM to IDLE.
REQ-020 LOCKED, match: exp <= next(exp), miss_cnt <= 0.
REQ-021 LOCKED, mismatch: exp <= next(exp) (free-run, no reseed), err_count +1, err_pulse=1 next cycle, miss_cnt++; on miss_cnt reaching LOSS_CNT, go to SYNC with match_cnt <= 0 and exp <= next(in_data).
REQ-022 locked and err_pulse are registered: both assert in the cycle after the qualifying valid sample.
REQ-023 err_count saturates at 2^CW-1 and never wraps.
REQ-024 clr sets err_count to 0; when clr and a counted mismatch occur in the same cycle, err_count becomes 1.
REQ-025 A change of mask while in SYNC or LOCKED is unsupported; the resulting behaviour is undefined but shall not hang the FSM.

Reset
REQ-026 Reset asserted: state=IDLE, exp=0, match_cnt=0, miss_cnt=0, locked=0, err_pulse=0, err_count=0, and all optional outputs 0, immediately and without waiting for a clock edge.
REQ-027 Reset asserted mid-operation discards all lock history; relock after release takes a fresh IDLE->SYNC sequence.

Configuration
REQ-028 Macro PRBS_CHECKER_PERIOD_EN, when defined, adds outputs period (CW bits) and period_valid (1 bit).
REQ-029 With PRBS_CHECKER_PERIOD_EN defined:
- Lock entry captures ref_word = the matching in_data sample.
- The block counts valid samples until in_data == ref_word recurs while LOCKED.
- On recurrence: period <= count, period_valid <= 1 (sticky until lock loss or reset), and the count restarts.
- The count saturates at 2^CW-1.
REQ-030 Without PRBS_CHECKER_PERIOD_EN, neither the period ports nor their logic exist, and all other behaviour is identical.

Verification (N=4, mask=0110; sequence from 0101: 0101,1011,0111,1110,1100,1001,0010,0101...)
REQ-031 Reset, then the sequence above with in_valid=1 every cycle -> locked=1 the cycle after the 5th valid sample (1 seed + 4 matches), err_count=0.
REQ-032 While locked, replace one sample 1110 with 1111 -> one err_pulse, err_count=1, locked stays 1, subsequent correct samples produce no further errors.
REQ-033 While locked, corrupt 3 consecutive samples -> err_count +3, locked=0 the cycle after the 3rd, relock 4 matches later.
REQ-034 in_data=0000 held valid from IDLE -> FSM stays IDLE, locked=0; assert clr together with a counted mismatch -> err_count=1.
REQ-035 Assert rst asynchronously while locked with err_count=5 -> locked=0 and err_count=0 before the next clk edge.
REQ-036 With PRBS_CHECKER_PERIOD_EN defined, run the sequence above -> period=7, period_valid=1 after the first recurrence of ref_word.
